sequencer_debug_cmd_bridge: RTL

SEQUENCER_DEBUG_CMD_BRIDGE -- requirements
Module: sequencer_debug_cmd_bridge

---
 rtl/sequencer_debug_cmd_bridge.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sequencer_debug_cmd_bridge.sv
// rtl/sequencer_debug_cmd_bridge.sv - JTAG debug command bridge: toggle synchronizers, command FIFO, one-hot strobes
module sequencer_debug_cmd_bridge #(
   parameter int DW          = 38,
   parameter int IRW         = 2,
   parameter int ACT_BIT     = 34,
   parameter int SYNC_STAGES = 3,
   parameter int DEPTH       = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [DW-1:0]            sr,
   input  logic [IRW-1:0]           ir_in,
   input  logic                     udr_tog,
   input  logic                     uir_tog,
   input  logic                     cmd_ready,
   input  logic                     ovf_clr,
   output logic                     cmd_valid,
   output logic [IRW-1:0]           cmd_ir,
   output logic [DW-1:0]            jdo,
   output logic [(1<<IRW)-1:0]      take_action,
   output logic [(1<<IRW)-1:0]      take_no_action,
   output logic                     ir_update,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int NCMD = 1 << IRW;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int EW   = IRW + DW;
   localparam int SCW  = $clog2(SYNC_STAGES + 2);

   logic [SYNC_STAGES-1:0] udr_sync;
   logic [SYNC_STAGES-1:0] uir_sync;
   logic                   udr_prev;
   logic                   uir_prev;
   logic [SCW-1:0]         sup_cnt;
   logic                   sup_done;
   logic                   udr_evt;
   logic                   uir_evt;

   logic [EW-1:0]          mem [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [CW-1:0]          count;
   logic [EW-1:0]          head;
   logic [IRW-1:0]         head_ir;
   logic [DW-1:0]          head_sr;
   logic [NCMD-1:0]        head_onehot;
   logic                   full;
   logic                   pop;
   logic                   push;
   logic                   ovf_set;

   // Two-flop-plus synchronizers for the toggle inputs, followed by a prev flop for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync <= '0;
         uir_sync <= '0;
         udr_prev <= 1'b0;
         uir_prev <= 1'b0;
      end else begin
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], udr_tog};
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], uir_tog};
         udr_prev <= udr_sync[SYNC_STAGES-1];
         uir_prev <= uir_sync[SYNC_STAGES-1];
      end
   end

   // Post-reset window: lets the chains settle so a toggle level already high at reset is not seen as an event
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sup_cnt <= '0;
      end else if (!sup_done) begin
         sup_cnt <= sup_cnt + 1'b1;
      end
   end

   assign sup_done = (sup_cnt == SCW'(SYNC_STAGES + 1));
   assign udr_evt  = sup_done & (udr_sync[SYNC_STAGES-1] ^ udr_prev);
   assign uir_evt  = sup_done & (uir_sync[SYNC_STAGES-1] ^ uir_prev);

   assign head        = mem[rd_ptr];
   assign head_ir     = head[EW-1:DW];
   assign head_sr     = head[DW-1:0];
   assign head_onehot = {{(NCMD-1){1'b0}}, 1'b1} << head_ir;

   assign full      = (count == CW'(DEPTH));
   assign cmd_valid = (count != '0);
   assign pop       = cmd_valid & cmd_ready;
   // A flush frees the whole queue, so a coincident push is always kept
   assign push      = udr_evt & (uir_evt | ~full | pop);
   assign ovf_set   = udr_evt & ~push;

   assign cmd_ir     = cmd_valid ? head_ir : '0;
   assign fifo_count = count;

   // Command storage; only entries between rd_ptr and wr_ptr are ever observed
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {ir_in, sr};
      end
   end

   // Pointer and occupancy bookkeeping, with flush restarting the queue at the write pointer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (uir_evt) begin
         rd_ptr <= wr_ptr;
         wr_ptr <= wr_ptr + AW'(push);
         count  <= CW'(push);
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Popped command drives jdo and a single one-cycle strobe; IR update pulse is registered alongside
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jdo            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         ir_update      <= 1'b0;
      end else begin
         take_action    <= '0;
         take_no_action <= '0;
         ir_update      <= uir_evt;
         if (pop) begin
            jdo <= head_sr;
            if (head_sr[ACT_BIT]) begin
               take_action <= head_onehot;
            end else begin
               take_no_action <= head_onehot;
            end
         end
      end
   end

   // Sticky drop flag; a new drop wins over a simultaneous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule
